round_key_store: RTL
====================

Name: round_key_store

Overview:
Buffers the AES-128 key schedule produced by the key-expansion stage. It captures each round key on the expander's write strobe and flags completion once all Nr+1 keys are held. It then streams the keys to the cipher round datapath over a valid/ready handshake, in forward order for encryption or reverse order for decryption. It sits directly downstream of round_key and upstream of the round pipeline.

Parameters:
KEY_S, 128, round-key width in bits (from aes.vh).
NR, 10, number of rounds; the store holds NR+1 keys (from aes.vh Nr).

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  asynchronous, active-low reset.
w_e  in  1  write strobe from the expander; round_key is valid in that cycle.
round_key  in  KEY_S  round key from the expander.
kexp_done  in  1  expander completion pulse (expander en_o).
rd_start  in  1  single-cycle request to stream the schedule.
rd_dec  in  1  direction, sampled with rd_start: 0 streams key 0..NR, 1 streams key NR..0.
out_ready  in  1  consumer ready.
out_key  out  KEY_S  current round key.
out_valid  out  1  out_key is valid.
out_last  out  1  out_key is the final key of the stream.
out_round  out  4  index of out_key within the schedule.
keys_valid  out  1  full schedule is held.
busy  out  1  state is LOAD or STREAM.
err_short  out  1  sticky; kexp_done arrived before NR+1 writes.

Behaviour:
- Reset (async assert, sync release):
  - State is EMPTY; wr_idx=0; rd_idx=0.
  - All outputs are 0.
  - Key storage is not reset; keys_valid gates its use.
- States: EMPTY, LOAD, READY, STREAM.
- EMPTY:
  - w_e writes key[0], sets wr_idx=1, goes to LOAD.
  - rd_start is ignored.
- LOAD:
  - Each w_e writes key[wr_idx] and increments wr_idx.
  - The write of index NR goes to READY; keys_valid=1 the next cycle.
  - kexp_done while in LOAD sets err_short, clears wr_idx, goes to EMPTY.
  - rd_start is ignored.
- READY:
  - rd_start latches rd_dec and sets rd_idx to 0 (enc) or NR (dec); goes to STREAM.
  - out_valid=1 from the next cycle.
  - w_e restarts the load: keys_valid=0, key[0] is written, wr_idx=1, go to LOAD.
  - kexp_done (normal end pulse) is ignored.
- STREAM:
  - out_key=key[rd_idx] and out_round=rd_idx, both registered.
  - out_last=1 when rd_idx is NR (enc) or 0 (dec).
  - Transfer occurs when out_valid and out_ready are both 1; rd_idx steps ±1 and the next key is presented the following cycle, with no bubble.
  - While out_valid=1 and out_ready=0, out_key, out_round and out_last hold stable.
  - Transfer with out_last=1: out_valid=0 and out_last=0 next cycle, go to READY.
  - w_e aborts the stream: out_valid=0 next cycle, keys_valid=0, key[0] written, go to LOAD.
  - rd_start is ignored.
- Simultaneous rd_start and w_e in READY: w_e wins and the request is dropped.
- Ordering: a write and a read of the same entry cannot occur, because reads only run in READY/STREAM.
- err_short clears only on reset.
- busy=1 in LOAD and STREAM.
- Reset asserted mid-stream or mid-load returns immediately to the reset state.

Decomposition:
- KEY_S, Nr and Nb stay in the shared aes.vh include.
- The state encoding and the index width, $clog2(NR+1), are local parameters.
- One sub-module, key_regfile: (NR+1)×KEY_S flop array with one synchronous write port and one combinational read port.
- The output register and the FSM live in round_key_store.

Test Plan:
- Load with key 5468617473206d79204b756e67204675:
  - Drive the 11 expander keys on w_e, then kexp_done.
  - keys_valid=1 one cycle after the 11th write; err_short=0.
- Forward stream: rd_start with rd_dec=0, out_ready=1.
  - 11 beats; beat0 = 5468617473206d79204b756e67204675, beat10 = 28fddef86da4244accc0a4fe3b316f26.
  - out_last=1 only on beat10.
  - State returns to READY.
- Reverse stream with backpressure: rd_dec=1, out_ready toggling 1,0,0,1.
  - First key is 28fd…6f26, held stable while stalled.
  - Last key is 5468…4675 with out_round=0 and out_last=1.
- Abort: w_e after 3 transfers of a stream.
  - out_valid=0 next cycle, keys_valid=0, busy=1.
  - Reloading then streaming yields the correct new schedule.
- Short load: 5 writes, then kexp_done.
  - err_short=1, keys_valid=0, state EMPTY.
  - rd_start is ignored (out_valid stays 0).
- Async reset mid-stream: pull reset low between clock edges.
  - out_valid, keys_valid and busy go 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/round_key_store_pkg.sv
// Shared AES-128 sizing and the state encoding for the round-key store.
// Imported by the top level and by the key register file.
package round_key_store_pkg;

  localparam int KEY_S = 128;
  localparam int NR    = 10;
  localparam int IDX_W = $clog2(NR + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY,
    ST_STREAM
  } state_t;

endpackage

// File: rtl/round_key_store_key_regfile.sv
// Flop array that holds the NR+1 round keys.
// It has one synchronous write port and one combinational read port.
module key_regfile
  import round_key_store_pkg::*;
#(
  parameter int WIDTH = KEY_S,
  parameter int DEPTH = NR + 1,
  parameter int AW    = IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately unreset; keys_valid at the top level qualifies its contents.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/round_key_store.sv
// Captures the expanded AES-128 schedule and replays it to the round datapath
// over valid/ready, in forward order for encryption or reverse order for decryption.
module round_key_store
  import round_key_store_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             w_e,
  input  logic [KEY_S-1:0] round_key,
  input  logic             kexp_done,
  input  logic             rd_start,
  input  logic             rd_dec,
  input  logic             out_ready,
  output logic [KEY_S-1:0] out_key,
  output logic             out_valid,
  output logic             out_last,
  output logic [3:0]       out_round,
  output logic             keys_valid,
  output logic             busy,
  output logic             err_short
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] wr_idx, rd_idx, rd_nxt, wr_addr;
  logic             dir_dec, xfer, start, advance, nxt_last;
  logic [KEY_S-1:0] rd_data;

  assign xfer    = (state == ST_STREAM) && out_valid && out_ready;
  assign start   = (state == ST_READY) && rd_start && !w_e;
  assign advance = start || (xfer && !out_last && !w_e);
  assign wr_addr = (state == ST_LOAD) ? wr_idx : '0;

  key_regfile u_regfile (
    .clk   (clk),
    .we    (w_e),
    .waddr (wr_addr),
    .wdata (round_key),
    .raddr (rd_nxt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      wr_idx    <= '0;
      err_short <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_LOAD) begin
        if (w_e) begin
          wr_idx <= (state == ST_LOAD) ? wr_idx + 1'b1 : IDX_W'(1);
        end
      end else begin
        wr_idx <= '0;
      end
      if ((state == ST_LOAD) && (state_nxt == ST_EMPTY)) begin
        err_short <= 1'b1;
      end
    end
  end

  // A write strobe always wins over a read request or an in-flight stream.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY:  if (w_e) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (w_e && (wr_idx == LAST_IDX)) state_nxt = ST_READY;
        else if (kexp_done)              state_nxt = ST_EMPTY;
      end
      ST_READY: begin
        if (w_e)           state_nxt = ST_LOAD;
        else if (rd_start) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_e)                   state_nxt = ST_LOAD;
        else if (xfer && out_last) state_nxt = ST_READY;
      end
      default:   state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    keys_valid = (state == ST_READY) || (state == ST_STREAM);
    busy       = (state == ST_LOAD)  || (state == ST_STREAM);
  end

  // The read port looks one step ahead so the next key lands in the output register without a bubble.
  always_comb begin
    rd_nxt = rd_idx;
    if (state == ST_READY) begin
      rd_nxt = rd_dec ? LAST_IDX : '0;
    end else if (dir_dec) begin
      rd_nxt = rd_idx - 1'b1;
    end else begin
      rd_nxt = rd_idx + 1'b1;
    end
    if ((state == ST_READY) ? rd_dec : dir_dec) begin
      nxt_last = (rd_nxt == '0);
    end else begin
      nxt_last = (rd_nxt == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx    <= '0;
      dir_dec   <= 1'b0;
      out_key   <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if ((state == ST_STREAM) && w_e) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (advance) begin
      rd_idx    <= rd_nxt;
      out_key   <= rd_data;
      out_round <= 4'(rd_nxt);
      out_last  <= nxt_last;
      out_valid <= 1'b1;
      if (start) begin
        dir_dec <= rd_dec;
      end
    end else if (xfer && out_last) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
